// File: rtl/io_arb_pkg.sv
// Shared constants for the I/O slave-port arbiter: FSM encoding and default bus widths.
package io_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  localparam int IO_ADDR_W = 24;
  localparam int IO_DATA_W = 32;
  localparam int IO_WE_W   = 3;

endpackage

// File: rtl/io_arbiter_if.sv
// Master-side request buses plus the single I/O slave port; slave modport is the arbiter's view.
interface io_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = io_arb_pkg::IO_ADDR_W,
  parameter int DATA_W  = io_arb_pkg::IO_DATA_W
);

  logic [NUM_REQ-1:0]                     m_req;
  logic [io_arb_pkg::IO_WE_W*NUM_REQ-1:0] m_we;
  logic [ADDR_W*NUM_REQ-1:0]              m_addr;
  logic [DATA_W*NUM_REQ-1:0]              m_wdata;
  logic [NUM_REQ-1:0]                     m_ack;
  logic [DATA_W-1:0]                      m_rdata;

  logic                                   io_en;
  logic [io_arb_pkg::IO_WE_W-1:0]         io_we;
  logic [ADDR_W-1:0]                      io_addr;
  logic [DATA_W-1:0]                      io_wdata;
  logic [DATA_W-1:0]                      io_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata, io_rdata,
    input  m_ack, m_rdata, io_en, io_we, io_addr, io_wdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, io_rdata,
    output m_ack, m_rdata, io_en, io_we, io_addr, io_wdata
  );

endinterface

// File: rtl/io_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after last+1 (mod NUM_REQ).
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W:0] idx;

  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    // i == NUM_REQ wraps back to last itself, so the previous winner has lowest priority
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = {1'b0, last} + (IDX_W+1)'(i);
      if (idx >= (IDX_W+1)'(NUM_REQ)) begin
        idx = idx - (IDX_W+1)'(NUM_REQ);
      end
      if (!any && req[idx[IDX_W-1:0]]) begin
        any       = 1'b1;
        grant_idx = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/io_arbiter.sv
// Round-robin arbiter sharing one I/O slave port: IDLE -> ISSUE (one slave cycle) -> ACK.
// Request-to-ack is two cycles, one access every three cycles; slave outputs are zero outside ISSUE.
module io_arbiter
  import io_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = IO_ADDR_W,
  parameter int DATA_W  = IO_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  io_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (bus.m_req),
    .last      (last_q),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    case (state_q)
      ST_ISSUE: begin
        state_d = ST_ACK;
        last_d  = sel_q;
        // captured verbatim on writes too; the master simply ignores it
        rdata_d = bus.io_rdata;
        for (int i = 0; i < NUM_REQ; i++) begin
          ack_d[i] = (sel_q == IDX_W'(i));
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        if (grant_any) begin
          state_d = ST_ISSUE;
          sel_d   = grant_idx;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    bus.io_en    = 1'b0;
    bus.io_we    = '0;
    bus.io_addr  = '0;
    bus.io_wdata = '0;
    if (state_q == ST_ISSUE) begin
      bus.io_en = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (sel_q == IDX_W'(i)) begin
          bus.io_we    = bus.m_we[i*IO_WE_W +: IO_WE_W];
          bus.io_addr  = bus.m_addr[i*ADDR_W +: ADDR_W];
          bus.io_wdata = bus.m_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign bus.m_ack   = ack_q;
  assign bus.m_rdata = rdata_q;

endmodule

// File: tb/tb_io_arbiter.sv
// Bench for io_arbiter with two masters and a small GPIO/UART register-file slave model.
module tb_io_arbiter;

  localparam int NR = 2;
  localparam int AW = 24;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  io_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // slave model: reg 1 is gpio_dir, reg 3 a read-only-ish status word
  logic [31:0] regs [8] = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
  assign bus.io_rdata = bus.io_en ? regs[bus.io_addr[2:0]] : 32'h0;

  always @(posedge clk) begin
    if (bus.io_en) begin
      if (bus.io_we[2]) regs[bus.io_addr[2:0]] <= bus.io_wdata;
      else begin
        if (bus.io_we[1]) regs[bus.io_addr[2:0]][15:0] <= bus.io_wdata[15:0];
        if (bus.io_we[0]) regs[bus.io_addr[2:0]][7:0]  <= bus.io_wdata[7:0];
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int ack_cnt  = 0;
  int en_cnt   = 0;
  int cyc      = 0;

  typedef struct {
    logic [1:0]  ack;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    int          master;
    logic [2:0]  we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [1:0]  exp_ack;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vt [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_req(input int m, input logic [2:0] we, input logic [23:0] addr,
                           input logic [31:0] wd);
    bus.m_we[m*3 +: 3]     = we;
    bus.m_addr[m*AW +: AW] = addr;
    bus.m_wdata[m*DW +: DW] = wd;
    bus.m_req[m]           = 1'b1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ack monitor against the scoreboard, plus the quiet-bus rule every cycle
  always @(negedge clk) begin
    if (bus.io_en === 1'b1) en_cnt++;
    if (bus.io_en === 1'b0)
      check("quiet_bus", {bus.io_we, bus.io_addr, bus.io_wdata}, 64'h0);
    if (bus.m_ack !== '0 && !$isunknown(bus.m_ack)) begin
      ack_cnt++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ack: got m_ack=%b, expected no ack", bus.m_ack);
      end else begin
        mon_e = sb.pop_front();
        check("ack_idx", bus.m_ack, mon_e.ack);
        check("ack_rdata", bus.m_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int waited;
    int t_prev;
    int en0;

    vt[0] = '{0, 3'b100, 24'h1, 32'hFF,        2'b01, 32'h0};
    vt[1] = '{1, 3'b000, 24'h3, 32'h0,         2'b10, 32'h1};
    vt[2] = '{1, 3'b000, 24'h1, 32'h0,         2'b10, 32'hFF};
    vt[3] = '{0, 3'b100, 24'h2, 32'hA5A51234,  2'b01, 32'h0};
    vt[4] = '{0, 3'b000, 24'h2, 32'h0,         2'b01, 32'hA5A51234};
    vt[5] = '{1, 3'b100, 24'h2, 32'h0,         2'b10, 32'hA5A51234};
    vt[6] = '{1, 3'b000, 24'h2, 32'h0,         2'b10, 32'h0};
    vt[7] = '{0, 3'b001, 24'h7, 32'h12345678,  2'b01, 32'hDEADBEEF};
    vt[8] = '{1, 3'b000, 24'h7, 32'h0,         2'b10, 32'hDEADBE78};

    bus.m_req = '0; bus.m_we = '0; bus.m_addr = '0; bus.m_wdata = '0;
    rst = 1'b1;
    step();
    check("rst_outputs", {bus.io_en, bus.io_we, bus.m_ack, bus.m_rdata}, 64'h0);
    step();
    rst = 1'b0;

    // reset then idle
    for (int k = 0; k < 20; k++) begin
      step();
      check("idle_quiet", {bus.io_en, bus.io_we, bus.m_ack}, 64'h0);
    end
    check("idle_rdata", bus.m_rdata, 32'h0);

    // single transactions from the table
    for (int i = 0; i < 9; i++) begin
      base = ack_cnt;
      sb.push_back('{vt[i].exp_ack, vt[i].exp_rdata});
      drive_req(vt[i].master, vt[i].we, vt[i].addr, vt[i].wdata);
      step();
      check("issue_en", bus.io_en, 1'b1);
      check("issue_bus", {bus.io_we, bus.io_addr, bus.io_wdata},
            {vt[i].we, vt[i].addr, vt[i].wdata});
      check("no_early_ack", ack_cnt, base);
      step();
      check("ack_latency", ack_cnt, base + 1);
      check("ack_phase_en", bus.io_en, 1'b0);
      bus.m_req = '0;
      step();
      check("back_idle_en", bus.io_en, 1'b0);
    end
    check("gpio_dir", regs[1][7:0], 8'hFF);
    repeat (3) step();
    check("rdata_hold", bus.m_rdata, 32'hDEADBE78);

    // contention from reset: grants alternate 0,1,0,1 three cycles apart
    rst = 1'b1;
    drive_req(0, 3'b000, 24'h3, 32'h0);
    drive_req(1, 3'b000, 24'h7, 32'h0);
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{2'b01, 32'h1});
      sb.push_back('{2'b10, 32'hDEADBE78});
    end
    step();
    rst = 1'b0;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      base = ack_cnt;
      waited = 0;
      while (ack_cnt == base && waited < 12) begin
        step();
        waited++;
      end
      check("contention_ack_seen", ack_cnt, base + 1);
      if (k > 0) check("ack_gap", cyc - t_prev, 3);
      t_prev = cyc;
    end
    bus.m_req = '0;
    repeat (4) step();
    check("contention_drained", sb.size(), 0);

    // reset during ISSUE aborts the access
    drive_req(0, 3'b000, 24'h3, 32'h0);
    base = ack_cnt;
    step();
    check("abort_issue_en", bus.io_en, 1'b1);
    rst = 1'b1;
    bus.m_req = '0;
    step();
    rst = 1'b0;
    check("abort_state", {bus.io_en, bus.m_ack}, 64'h0);
    check("abort_rdata", bus.m_rdata, 32'h0);
    repeat (3) step();
    check("abort_no_ack", ack_cnt, base);
    sb.push_back('{2'b10, 32'h1});
    drive_req(1, 3'b000, 24'h3, 32'h0);
    step();
    check("post_rst_issue", {bus.io_en, bus.io_addr}, {1'b1, 24'h3});
    step();
    check("post_rst_latency", ack_cnt, base + 1);
    bus.m_req = '0;
    repeat (2) step();

    // master drops m_req during ISSUE
    en0 = en_cnt;
    base = ack_cnt;
    sb.push_back('{2'b01, 32'h0});
    drive_req(0, 3'b100, 24'h4, 32'h55);
    step();
    check("drop_issue_en", bus.io_en, 1'b1);
    bus.m_req = '0;
    step();
    check("drop_ack_seen", ack_cnt, base + 1);
    repeat (5) step();
    check("drop_single_access", en_cnt - en0, 1);
    check("drop_write_landed", regs[4], 32'h55);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
